// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: RiSC-16 instruction fetch stage.
//   Issues sequential word-address reads to instruction memory, tracks
//   in-flight reads, buffers responses in a prefetch FIFO and hands them to
//   decode over a valid/ready handshake. A redirect flushes the FIFO, marks
//   in-flight responses for discard and restarts fetch at redirect_pc.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_valid/ready/addr    instruction memory read request
//   imem_rsp_valid/data          in-order read responses (latency >= 1)
//   redirect_valid/pc            one-cycle restart pulse and new PC
//   inst_valid/ready/data/pc     head-of-FIFO instruction to decode
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, outstanding, discard;
  logic [ADDR_W-1:0] fetch_pc, head_pc;

  logic [CNT_W:0] occupancy;
  logic           credit, accept, push, pop, drop;

  always_comb begin
    // Buffered plus in-flight entries never exceed the FIFO, so responses
    // can always be accepted without backpressure.
    occupancy      = {1'b0, count} + {1'b0, outstanding};
    credit         = occupancy < DEPTH_C;
    imem_req_valid = credit && !redirect_valid && !rst;
    imem_req_addr  = fetch_pc;
    accept         = imem_req_valid && imem_req_ready;

    inst_valid     = count != '0;
    inst_data      = inst_valid ? fifo_mem[rd_ptr] : '0;
    inst_pc        = head_pc;

    // During a redirect the FIFO is flushed, so neither push nor pop apply.
    pop            = inst_valid && inst_ready && !redirect_valid;
    push           = imem_rsp_valid && (discard == '0) && !redirect_valid;
    drop           = imem_rsp_valid && (discard != '0) && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // Every read still in flight after this cycle belongs to the old path;
      // a response arriving now is dropped along with the flush.
      if (imem_rsp_valid) begin
        outstanding <= outstanding - CNT_ONE;
        discard     <= outstanding - CNT_ONE;
      end else begin
        discard     <= outstanding;
      end
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + PC_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        head_pc <= head_pc + PC_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (accept && !imem_rsp_valid) begin
        outstanding <= outstanding + CNT_ONE;
      end else if (!accept && imem_rsp_valid) begin
        outstanding <= outstanding - CNT_ONE;
      end
      if (drop) begin
        discard <= discard - CNT_ONE;
      end
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized self-checking bench for inst_fetch_unit.
//   Drives an in-order instruction memory (data = addr ^ 16'hA5A5) and
//   compares every cycle against a queue-based reference of the fetch rules.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;

  inst_fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; bit stale; } flight_t;
  typedef struct { logic [15:0] addr; int due; } mem_rd_t;

  // Reference: instructions waiting for decode, reads the model expects in
  // flight (stale ones belong to a path abandoned by a redirect).
  logic [15:0] fq[$];
  flight_t     iq[$];
  logic [15:0] m_fetch = 16'h0000;
  logic [15:0] m_head  = 16'h0000;
  // Memory stimulus: reads the DUT actually issued, released after latency.
  mem_rd_t     mq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit redir, input logic [15:0] rpc,
                      input bit rdy, input bit irdy, input int lat);
    bit          rsp, exp_rv, acc;
    logic [15:0] acc_addr;
    flight_t     e;
    @(negedge clk);
    rst = r; redirect_valid = redir; redirect_pc = rpc;
    imem_req_ready = rdy; inst_ready = irdy;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (mq[0].addr ^ 16'hA5A5) : 16'($urandom);
    #1;
    exp_rv = !r && !redir && ((fq.size() + iq.size()) < 4);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (!r) check("req_addr", 32'(imem_req_addr), 32'(m_fetch));
    check("inst_valid", 32'(inst_valid), 32'(fq.size() > 0));
    check("inst_pc", 32'(inst_pc), 32'(m_head));
    if (fq.size() > 0) begin
      check("inst_pc_q", 32'(inst_pc), 32'(fq[0]));
      check("inst_data", 32'(inst_data), 32'(fq[0] ^ 16'hA5A5));
    end else begin
      check("inst_data0", 32'(inst_data), 32'h0);
    end
    acc = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (acc) n_acc++;
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else begin
      if (rsp) void'(mq.pop_front());
      if (acc) mq.push_back('{acc_addr, cyc + lat});
    end
    if (r) begin
      fq.delete(); iq.delete(); m_fetch = 16'h0000; m_head = 16'h0000;
    end else if (redir) begin
      if (rsp && iq.size() > 0) void'(iq.pop_front());
      foreach (iq[i]) iq[i].stale = 1'b1;
      fq.delete();
      m_fetch = rpc; m_head = rpc;
    end else begin
      if (fq.size() > 0 && irdy) begin
        void'(fq.pop_front());
        m_head++;
      end
      if (rsp) begin
        if (iq.size() == 0) begin
          check("rsp_without_req", 32'h1, 32'h0);
        end else begin
          e = iq.pop_front();
          if (!e.stale) fq.push_back(e.pc);
        end
      end
      if (exp_rv && rdy) begin
        iq.push_back('{m_fetch, 1'b0});
        m_fetch++;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [15:0] rpc;
    bit          rd;
    int          lat;

    // 1: reset, then stream with 1-cycle memory
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 1);

    // 2: decode stalls; exactly four requests fill the buffer
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    n_acc = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 1);
    check("stall_req_count", 32'(n_acc), 32'd4);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1);

    // 3: 3-cycle latency, redirect with reads in flight
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 3);
    step(0, 1, 16'h0040, 1, 1, 3);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 3);

    // 4: redirect coinciding with a response and a pop
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);
    check("rsp_in_redirect_cycle", 32'(mq.size() > 0 && mq[0].due <= cyc), 32'h1);
    step(0, 1, 16'h1234, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);

    // 5: wrap of both fetch and head PC
    step(0, 1, 16'hFFFE, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 2);

    // Randomized traffic: ready, decode stalls, latency, redirects
    for (int i = 0; i < 800; i++) begin
      lat = int'($urandom_range(1, 4));
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(0, rd, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, lat);
    end

    // 6: memory stall holds the address, then reset mid-stall
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 2);
    step(1, 0, 0, 0, 0, 2);
    step(1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
